// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and sizing helpers for the FIFO burst reader.
package fifo_burst_reader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Width of a counter that must hold the value burst_len itself.
    function automatic int BEAT_W(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/burst_out_reg.sv
// Single-entry valid/ready register slice carrying one beat of data plus its last flag.
module burst_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    // The owner only loads when the slot is empty or being accepted,
    // so data and last never change under a stalled beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains an FWFT FIFO in fixed-length bursts onto a valid/ready stream; flush sends the residue.
// Optional idle-timeout partial bursts are enabled with `define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_ren_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_count_i,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o
);

    localparam int              BW       = BEAT_W(BURST_LEN);
    localparam int              CW       = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   LP_BURST = CW'(BURST_LEN);
    localparam logic [BW-1:0]   LP_BEATS = BW'(BURST_LEN);

    state_e         r_state;
    logic [BW-1:0]  r_beats_left;
    logic           r_flush_pend;

    logic           w_pop;
    logic           w_full;
    logic           w_part;
    logic           w_tmo;
    logic           w_last;

    assign w_full = (fifo_count_i >= LP_BURST);
    assign w_part = (r_flush_pend || w_tmo) && (fifo_count_i != '0);
    assign w_last = (r_beats_left == BW'(1));

    // Pop is held off during reset so the FIFO is left untouched.
    assign w_pop      = !rst && (r_state == BURST) && !fifo_empty_i &&
                        (!m_valid_o || m_ready_i);
    assign fifo_ren_o = w_pop;
    assign busy_o     = (r_state == BURST) | m_valid_o;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_idle_cnt;

    assign w_tmo = (r_idle_cnt == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (r_state == IDLE && (w_full || w_part)) begin
            r_idle_cnt <= '0;
        end else if (r_state == IDLE && fifo_count_i != '0 && !w_full) begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    // TIMEOUT is never negative, so the timeout path is tied off.
    assign w_tmo = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_full) begin
                        r_state      <= BURST;
                        r_beats_left <= LP_BEATS;
                    end else if (w_part) begin
                        // count is below BURST_LEN here, so it is already the min.
                        r_state      <= BURST;
                        r_beats_left <= BW'(fifo_count_i);
                        r_flush_pend <= 1'b0;
                    end else if (r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                    end
                end
                BURST: begin
                    if (w_pop) begin
                        r_beats_left <= r_beats_left - BW'(1);
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (flush_i) r_flush_pend <= 1'b1;
        end
    end

    burst_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_pop),
        .i_data  (fifo_rdata_i),
        .i_last  (w_last),
        .i_ready (m_ready_i),
        .o_valid (m_valid_o),
        .o_data  (m_data_o),
        .o_last  (m_last_o)
    );

endmodule
